video_ram_dual_fill: RTL
========================

Name: video_ram_dual_fill

Overview:
Parametrised successor of the single-read-port video RAM: one write port with lane enables, two independent synchronous read ports, and a hardware fill engine.
- Read port A serves the CPU/readback path; read port B serves the VGA scan-out path.
- The fill engine sweeps every word to a constant, for clear-screen and background colour, without CPU involvement.
- Sits between the CPU write path and the VGA controller.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH
LANE_WIDTH, 8, bits per write-enable lane
ADDR_WIDTH, 8, address width
MEM_SIZE, 256, number of words; valid addresses 0..MEM_SIZE-1; MEM_SIZE <= 2**ADDR_WIDTH
READ_FIRST, 1, same-address read/write collision: 1 returns old data, 0 returns new (merged) data
OUT_REG, 0, 1 adds an output register on both read ports (latency 2 instead of 1)

Ports:
Clock  in  1  single clock, all logic on rising edge
Reset  in  1  synchronous, active-high
iWriteEnable  in  1  write request
iWriteAddress  in  ADDR_WIDTH  write address
iLaneEnable  in  DATA_WIDTH/LANE_WIDTH  per-lane write mask; bit k covers bits [k*LANE_WIDTH +: LANE_WIDTH]
iDataIn  in  DATA_WIDTH  write data
iReadAddressA  in  ADDR_WIDTH  port A read address
oDataOutA  out  DATA_WIDTH  port A read data
iReadAddressB  in  ADDR_WIDTH  port B read address
oDataOutB  out  DATA_WIDTH  port B read data
iFillStart  in  1  start-fill request, sampled in IDLE only
iFillValue  in  DATA_WIDTH  fill word, captured on the accepted iFillStart
oFillBusy  out  1  high while the fill engine is in FILL
oFillDone  out  1  one-cycle pulse when the fill completes
oWriteDropped  out  1  one-cycle pulse, registered: the previous cycle's external write was discarded

Behaviour:
- Reset: oDataOutA/B=0, oFillBusy=0, oFillDone=0, oWriteDropped=0, FSM=IDLE, fill counter=0.
- Memory array contents are not cleared by Reset; a fill interrupted by Reset leaves its partially written contents in place.
- Read latency:
  - Address sampled at edge N; data valid after edge N+1+OUT_REG.
  - Both ports are fully independent and are read every cycle; there is no read enable.
- Out-of-range address (>= MEM_SIZE):
  - Write is ignored; no oWriteDropped.
  - Read returns 0.
- External write: when iWriteEnable=1 and FSM=IDLE, each lane with iLaneEnable[k]=1 is written; lanes with 0 keep old contents. iLaneEnable=0 writes nothing.
- Collision (read address equals the effective write address in the same cycle), per port:
  - READ_FIRST=1: the read returns the pre-write word.
  - READ_FIRST=0: the read returns the post-write word (lane-merged).
  - The same rule applies to fill-engine writes.
- Fill FSM:
  - IDLE: iFillStart=1 captures iFillValue, clears the counter and moves to FILL. An external write in that same cycle still executes.
  - FILL:
    - Each cycle writes the fill word, all lanes, to address = counter, then increments the counter.
    - oFillBusy=1 in this state.
    - Move to DONE after the write to MEM_SIZE-1; FILL lasts exactly MEM_SIZE cycles.
  - DONE: lasts one cycle; oFillDone=1, oFillBusy=0; then IDLE.
- During FILL and DONE:
  - iWriteEnable=1 with an in-range address is discarded; oWriteDropped pulses on the following cycle.
  - iFillStart is ignored.
  - Reads continue normally and observe fill progress.
- Reset mid-fill: the next cycle is IDLE with oFillBusy=0 and no oFillDone pulse.
- The counter is ADDR_WIDTH+1 bits wide, so that MEM_SIZE=2**ADDR_WIDTH terminates without wrap.

Test Plan:
- Write 0xABCD to addr 5 with lanes 2'b11, then read A=5 -> oDataOutA=0xABCD one cycle later (OUT_REG=0) and two cycles later (OUT_REG=1).
- Addr 5 holds 0xABCD; write 0x1234 with lanes 2'b01 -> subsequent reads return 0xAB34; lanes 2'b00 -> no change.
- Collision: addr 7 holds 0x0001; write 0x0002 to addr 7 while A=B=7 -> both read 0x0001 (READ_FIRST=1) or 0x0002 (READ_FIRST=0).
- Fill 0x00FF:
  - oFillBusy is high for 256 cycles, then oFillDone pulses once.
  - Port B sweep 0..255 afterwards reads 0x00FF everywhere.
  - An external write during the fill produces an oWriteDropped pulse and leaves the memory unchanged.
- Reset 10 cycles into a fill of 0x5555:
  - Addrs 0..9 read 0x5555; addr 10 onward keep their old data.
  - oFillDone never pulses; a new iFillStart is accepted immediately.
- Write to addr 300 with MEM_SIZE=256, ADDR_WIDTH=9 -> no write and no oWriteDropped; a read of addr 300 returns 0.

Source files
------------

// File: rtl/video_ram_dual_fill_if.sv
// Bus bundle for the dual-read video RAM: CPU write port, two read ports, fill control.
interface video_ram_dual_fill_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  iWriteEnable;
  logic [ADDR_WIDTH-1:0] iWriteAddress;
  logic [LANES-1:0]      iLaneEnable;
  logic [DATA_WIDTH-1:0] iDataIn;
  logic [ADDR_WIDTH-1:0] iReadAddressA;
  logic [DATA_WIDTH-1:0] oDataOutA;
  logic [ADDR_WIDTH-1:0] iReadAddressB;
  logic [DATA_WIDTH-1:0] oDataOutB;
  logic                  iFillStart;
  logic [DATA_WIDTH-1:0] iFillValue;
  logic                  oFillBusy;
  logic                  oFillDone;
  logic                  oWriteDropped;

  modport master (
    output iWriteEnable, iWriteAddress, iLaneEnable, iDataIn,
    output iReadAddressA, iReadAddressB, iFillStart, iFillValue,
    input  oDataOutA, oDataOutB, oFillBusy, oFillDone, oWriteDropped
  );

  modport slave (
    input  iWriteEnable, iWriteAddress, iLaneEnable, iDataIn,
    input  iReadAddressA, iReadAddressB, iFillStart, iFillValue,
    output oDataOutA, oDataOutB, oFillBusy, oFillDone, oWriteDropped
  );
endinterface

// File: rtl/video_ram_dual_fill.sv
// Video RAM: lane-masked write port, two synchronous read ports, hardware fill engine.
module video_ram_dual_fill #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 256,
  parameter int unsigned READ_FIRST = 1,
  parameter int unsigned OUT_REG    = 0
) (
  input logic Clock,
  input logic Reset,
  video_ram_dual_fill_if.slave bus
);
  localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] MEM_SIZE_C = CNT_W'(MEM_SIZE);
  localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(MEM_SIZE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
  logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;

  logic                  wr_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [IDX_W-1:0]      wr_idx_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [DATA_WIDTH-1:0] wr_mask_c;
  logic [DATA_WIDTH-1:0] wr_word_c;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < MEM_SIZE_C;
  endfunction

  // Effective write: fill engine owns the port in FILL, CPU only in IDLE; merged word for collisions.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = bus.iWriteAddress;
    wr_data_c = bus.iDataIn;
    wr_mask_c = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      wr_mask_c[k*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{bus.iLaneEnable[k]}};
    end
    if (!Reset) begin
      if (state_q == ST_FILL) begin
        wr_en_c   = 1'b1;
        wr_addr_c = cnt_q[ADDR_WIDTH-1:0];
        wr_data_c = fill_val_q;
        wr_mask_c = '1;
      end else if (state_q == ST_IDLE && bus.iWriteEnable &&
                   in_range(bus.iWriteAddress) && (|bus.iLaneEnable)) begin
        wr_en_c = 1'b1;
      end
    end
    wr_idx_c  = IDX_W'(wr_addr_c);
    wr_word_c = (mem_q[wr_idx_c] & ~wr_mask_c) | (wr_data_c & wr_mask_c);
  end

  // Read ports: out-of-range returns zero; write-first bypass when READ_FIRST is cleared.
  always_comb begin
    rd_a_d = in_range(bus.iReadAddressA) ? mem_q[IDX_W'(bus.iReadAddressA)] : '0;
    rd_b_d = in_range(bus.iReadAddressB) ? mem_q[IDX_W'(bus.iReadAddressB)] : '0;
    if (READ_FIRST == 0 && wr_en_c && wr_addr_c == bus.iReadAddressA) rd_a_d = wr_word_c;
    if (READ_FIRST == 0 && wr_en_c && wr_addr_c == bus.iReadAddressB) rd_b_d = wr_word_c;
  end

  // Fill FSM next-state, counter and status flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    drop_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.iFillStart) begin
          fill_val_d = bus.iFillValue;
          cnt_d      = '0;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_C) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && bus.iWriteEnable && in_range(bus.iWriteAddress)) drop_d = 1'b1;
    busy_d = (state_d == ST_FILL);
    done_d = (state_d == ST_DONE);
  end

  // Control and read-data registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge Clock) begin
    if (wr_en_c) mem_q[wr_idx_c] <= wr_word_c;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_a_q, out_b_q;
    // Optional second pipeline stage on both read ports.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        out_a_q <= '0;
        out_b_q <= '0;
      end else begin
        out_a_q <= rd_a_q;
        out_b_q <= rd_b_q;
      end
    end
    assign bus.oDataOutA = out_a_q;
    assign bus.oDataOutB = out_b_q;
  end else begin : g_no_out_reg
    assign bus.oDataOutA = rd_a_q;
    assign bus.oDataOutB = rd_b_q;
  end

  assign bus.oFillBusy     = busy_q;
  assign bus.oFillDone     = done_q;
  assign bus.oWriteDropped = drop_q;
endmodule
